esfa_cell_result_reducer: RTL

- Downstream consumer of the ESFA memory-cell array.
- After a selector (lookUpScan, encode, markAvailableCell, enrank, ...) is broadcast to all cells, it scans the per-cell registered outputs (new_bool, new_result_value, new_context) one cell per cycle.
- Returns a single priority-resolved result: the lowest-indexed matching cell's handle, value and context, plus the total match count.
- Hands the result to the controller over a valid/ready handshake.

---
 rtl/esfa_cell_result_reducer_if.sv | 29 ++
 rtl/esfa_cell_result_reducer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/esfa_cell_result_reducer_if.sv
// Handshake and cell-array bus between the ESFA cell array/controller and the result reducer.
// The reducer uses the slave modport; the controller or testbench uses the master modport.
interface esfa_cell_result_reducer_if #(
  parameter int NUM_CELLS  = 8,
  parameter int DATA_WIDTH = 8
);
  logic                             start;
  logic [NUM_CELLS-1:0]             cell_bool;
  logic [NUM_CELLS*DATA_WIDTH-1:0]  cell_value;
  logic [NUM_CELLS*DATA_WIDTH-1:0]  cell_context;
  logic                             busy;
  logic                             result_valid;
  logic                             result_ready;
  logic                             hit;
  logic [7:0]                       first_handle;
  logic [DATA_WIDTH-1:0]            first_value;
  logic [DATA_WIDTH-1:0]            first_context;
  logic [7:0]                       match_count;

  modport master (
    output start, cell_bool, cell_value, cell_context, result_ready,
    input  busy, result_valid, hit, first_handle, first_value, first_context, match_count
  );

  modport slave (
    input  start, cell_bool, cell_value, cell_context, result_ready,
    output busy, result_valid, hit, first_handle, first_value, first_context, match_count
  );
endinterface

// File: rtl/esfa_cell_result_reducer.sv
// Scans ESFA cell outputs one cell per cycle and returns the lowest-indexed match,
// its value/context and the total match count over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; last result retained
// WAIT  | cell outputs settling for CELL_LATENCY edges
// SCAN  | one cell examined per edge, index 0 upward
// DONE  | result_valid high until result_ready
module esfa_cell_result_reducer #(
  parameter int NUM_CELLS    = 8,
  parameter int CELL_LATENCY = 1,
  parameter int DATA_WIDTH   = 8
) (
  input logic                     clk,
  input logic                     reset,
  esfa_cell_result_reducer_if.slave bus
);

  localparam int IW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int WW = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CELLS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(CELL_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state, state_next;
  logic [WW-1:0]         wait_cnt, wait_next;
  logic [IW-1:0]         idx, idx_next;
  logic                  hit, hit_next;
  logic [7:0]            handle, handle_next;
  logic [DATA_WIDTH-1:0] value, value_next;
  logic [DATA_WIDTH-1:0] ctx, ctx_next;
  logic [7:0]            count, count_next;

  logic                  sel_bool;
  logic [DATA_WIDTH-1:0] sel_value;
  logic [DATA_WIDTH-1:0] sel_ctx;

  // Cell select mux; inputs are sampled live since the controller holds them while busy.
  always_comb begin
    sel_bool  = 1'b0;
    sel_value = '0;
    sel_ctx   = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == IW'(i)) begin
        sel_bool  = bus.cell_bool[i];
        sel_value = bus.cell_value[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ctx   = bus.cell_context[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    idx_next    = idx;
    hit_next    = hit;
    handle_next = handle;
    value_next  = value;
    ctx_next    = ctx;
    count_next  = count;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          hit_next    = 1'b0;
          handle_next = '0;
          value_next  = '0;
          ctx_next    = '0;
          count_next  = '0;
          wait_next   = '0;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == LAST_WAIT) begin
          idx_next   = '0;
          state_next = ST_SCAN;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      ST_SCAN: begin
        if (sel_bool) begin
          count_next = count + 8'd1;
          if (!hit) begin
            hit_next    = 1'b1;
            handle_next = 8'(idx);
            value_next  = sel_value;
            ctx_next    = sel_ctx;
          end
        end
        if (idx == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      idx      <= '0;
      hit      <= 1'b0;
      handle   <= '0;
      value    <= '0;
      ctx      <= '0;
      count    <= '0;
    end else begin
      wait_cnt <= wait_next;
      idx      <= idx_next;
      hit      <= hit_next;
      handle   <= handle_next;
      value    <= value_next;
      ctx      <= ctx_next;
      count    <= count_next;
    end
  end

  assign bus.busy          = (state != ST_IDLE);
  assign bus.result_valid  = (state == ST_DONE);
  assign bus.hit           = hit;
  assign bus.first_handle  = handle;
  assign bus.first_value   = value;
  assign bus.first_context = ctx;
  assign bus.match_count   = count;

endmodule
